// File: rtl/debounce_pkg.sv
//------------------------------------------------------------------------------
// Module : debounce_pkg
// Brief  : Shared state encoding and sizing helper for the multi-channel debouncer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package debounce_pkg;

  typedef enum logic [1:0] {
    S_0       = 2'b00,
    S_MAYBE_1 = 2'b01,
    S_1       = 2'b10,
    S_MAYBE_0 = 2'b11
  } debounce_state_t;

  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
//------------------------------------------------------------------------------
// Module : debounce_channel
// Brief  : One channel: input synchroniser, confirm FSM with tick counter, edge strobes.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module debounce_channel
  import debounce_pkg::*;
#(
  parameter int BOUNCE_TICKS = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int c_cnt_w = cnt_width(BOUNCE_TICKS);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  debounce_state_t        r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= raw;
      end
    end else begin : g_sync_chain
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      end
    end
  endgenerate

  assign w_s = r_sync[SYNC_STAGES-1];

  // Pulses are set on the same edge as the confirming state change, so they
  // coincide with the first cycle of the new level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        S_0: begin
          if (w_s) begin
            r_state <= S_MAYBE_1;
            r_cnt   <= '0;
          end
        end
        S_MAYBE_1: begin
          if (!w_s) begin
            r_state <= S_0;
          end else if (tick) begin
            if (r_cnt == c_cnt_last) begin
              r_state <= S_1;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
            end else if (r_cnt < c_cnt_last) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_1: begin
          if (!w_s) begin
            r_state <= S_MAYBE_0;
            r_cnt   <= '0;
          end
        end
        S_MAYBE_0: begin
          if (w_s) begin
            r_state <= S_1;
          end else if (tick) begin
            if (r_cnt == c_cnt_last) begin
              r_state <= S_0;
              r_level <= 1'b0;
              r_fall  <= 1'b1;
            end else if (r_cnt < c_cnt_last) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
//------------------------------------------------------------------------------
// Module : multi_debouncer
// Brief  : N-channel debouncer with a shared tick prescaler and synchronised reset release.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int BOUNCE_TICKS = 10,
  parameter int TICK_DIV     = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] bouncy_in,
  output logic [N_CH-1:0] debounced_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            any_change
);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic       w_tick;

  // Assert immediately, release on a common edge for every channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= '0;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  generate
    if (TICK_DIV == 1) begin : g_tick_every
      assign w_tick = 1'b1;
    end else begin : g_prescaler
      localparam int c_pre_w = $clog2(TICK_DIV);
      localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
      logic [c_pre_w-1:0] r_pre;

      always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                r_pre <= '0;
        else if (r_pre == c_pre_last) r_pre <= '0;
        else                         r_pre <= r_pre + 1'b1;
      end

      assign w_tick = (r_pre == c_pre_last);
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
        .BOUNCE_TICKS (BOUNCE_TICKS),
        .SYNC_STAGES  (SYNC_STAGES)
      ) u_channel (
        .clk   (clk),
        .rst   (w_rst_n),
        .tick  (w_tick),
        .raw   (bouncy_in[i]),
        .level (debounced_out[i]),
        .rise  (rise_pulse[i]),
        .fall  (fall_pulse[i])
      );
    end
  endgenerate

  assign any_change = |{rise_pulse, fall_pulse};

endmodule

`default_nettype wire
